// File: rtl/barr_pipe.sv
// Pipelined multi-lane signed Barrett reducer.
// Three register stages (S1 multiply, S2 quotient estimate, S3 subtract/fold).
// Per-beat canon flag selects centred or canonical [0,Q) output.
// Every stage shifts together on adv, so bubbles are kept rather than squeezed out.
module barr_pipe #(
    parameter int LANES  = 2,
    parameter int DATA_W = 16,
    parameter int Q      = 3329,
    parameter int V      = 20159,
    parameter int SHIFT  = 26
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      clear_i,
    input  logic                      valid_i,
    output logic                      ready_o,
    input  logic                      canon_i,
    input  logic [LANES*DATA_W-1:0]   data_i,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic [LANES*DATA_W-1:0]   data_o
);

    // Product width: wide enough for a = -2^(DATA_W-1) plus the rounding constant.
    localparam int PW = DATA_W + $clog2(V) + 2;
    // Remainder width: one bit beyond the lane so a - t*Q cannot wrap.
    localparam int RW = DATA_W + 1;

    localparam logic signed [PW-1:0] V_S = PW'(V);
    localparam logic signed [PW-1:0] RND = PW'(1) << (SHIFT - 1);
    localparam logic signed [RW-1:0] Q_S = RW'(Q);

    logic adv;
    logic v1, v2, v3;
    logic c1, c2;

    assign adv     = ready_i | ~v3;
    assign ready_o = adv;
    assign valid_o = v3;

    // Stage valids and canon flags; clear wins over acceptance and advance.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
            c1 <= 1'b0;
            c2 <= 1'b0;
        end else if (clear_i) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else if (adv) begin
            v1 <= valid_i;
            v2 <= v1;
            v3 <= v2;
            c1 <= canon_i;
            c2 <= c1;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic signed [DATA_W-1:0] a_in;
        logic signed [DATA_W-1:0] a1;
        logic signed [DATA_W-1:0] a2;
        logic signed [PW-1:0]     a_ext;
        logic signed [PW-1:0]     p_n;
        logic signed [PW-1:0]     p1;
        logic signed [PW-1:0]     sum;
        logic signed [RW-1:0]     t_n;
        logic signed [RW-1:0]     tq_n;
        logic signed [RW-1:0]     tq2;
        logic signed [RW-1:0]     r_n;
        logic signed [DATA_W-1:0] r3;

        assign a_in  = data_i[k*DATA_W +: DATA_W];
        assign a_ext = {{(PW-DATA_W){a_in[DATA_W-1]}}, a_in};
        assign p_n   = a_ext * V_S;
        assign sum   = p1 + RND;
        // Quotient estimate is at most about 2^(DATA_W-1)/Q in magnitude, so RW bits hold it.
        assign t_n   = RW'(sum >>> SHIFT);
        assign tq_n  = t_n * Q_S;
        assign r_n   = {a2[DATA_W-1], a2} - tq2;

        // Lane datapath: multiply, estimate quotient, subtract and optionally fold into [0,Q).
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                a1  <= '0;
                p1  <= '0;
                a2  <= '0;
                tq2 <= '0;
                r3  <= '0;
            end else if (adv) begin
                a1  <= a_in;
                p1  <= p_n;
                a2  <= a1;
                tq2 <= tq_n;
                r3  <= DATA_W'((c2 && r_n[RW-1]) ? (r_n + Q_S) : r_n);
            end
        end

        assign data_o[k*DATA_W +: DATA_W] = r3;
    end

endmodule

// File: tb/tb_barr_pipe.sv
// Scoreboard bench for barr_pipe: the driver queues the expected result of every accepted beat,
// and a separate monitor pops and compares on each output handshake.
module tb_barr_pipe;

    localparam int LANES = 2;
    localparam int DW    = 16;
    localparam int W     = LANES * DW;
    localparam int Q     = 3329;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         clear = 1'b0;
    logic         valid_in = 1'b0;
    logic         ready_out;
    logic         canon = 1'b0;
    logic [W-1:0] din = '0;
    logic         valid_out;
    logic         ready_in = 1'b0;
    logic [W-1:0] dout;

    int           errors = 0;
    int           checks = 0;
    int           cyc = 0;
    int           acc_cyc = 0;
    bit           fire;
    logic [W-1:0] exp_q[$];

    barr_pipe #(.LANES(LANES), .DATA_W(DW), .Q(Q), .V(20159), .SHIFT(26)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .clear_i (clear),
        .valid_i (valid_in),
        .ready_o (ready_out),
        .canon_i (canon),
        .data_i  (din),
        .valid_o (valid_out),
        .ready_i (ready_in),
        .data_o  (dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] pk(input int a0, input int a1);
        logic [W-1:0] r;
        r[DW-1:0]  = DW'(a0);
        r[W-1:DW]  = DW'(a1);
        return r;
    endfunction

    // Independent reference: true modular residue, then centred if requested.
    function automatic int mref(input int a, input bit c);
        int m;
        m = a % Q;
        if (m < 0) m = m + Q;
        if (!c && m > (Q - 1) / 2) m = m - Q;
        return m;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got {%0d,%0d} expected {%0d,%0d}", name,
                     $signed(act[DW-1:0]), $signed(act[W-1:DW]),
                     $signed(expv[DW-1:0]), $signed(expv[W-1:DW]));
        end
    endtask

    task automatic chk_int(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Drive one cycle of inputs just after a falling edge; queue the expectation if accepted.
    task automatic step(input bit v, input logic [W-1:0] d, input bit c, input bit rdy,
                        input bit clr, input logic [W-1:0] e);
        valid_in = v;
        din      = d;
        canon    = c;
        ready_in = rdy;
        clear    = clr;
        #1;
        fire = v && ready_out && !clr;
        if (fire) begin
            exp_q.push_back(e);
            acc_cyc = cyc;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 50) begin
            idle();
            k++;
        end
        chk_int(name, exp_q.size(), 0);
    endtask

    task automatic check_latency(input string name);
        int a;
        int k;
        a = acc_cyc;
        k = 0;
        while (!valid_out && k < 10) begin
            idle();
            k++;
        end
        chk_int(name, cyc - a, 3);
    endtask

    // Monitor: handshake compare, hold stability, ready_o relation, and flush on clear.
    initial begin
        logic         held;
        logic [W-1:0] hd;
        held = 1'b0;
        hd   = '0;
        @(posedge rst_n);
        forever begin
            @(negedge clk);
            #2;
            chk_int("ready_o_rel", int'(ready_out), int'(ready_in || !valid_out));
            if (held) begin
                chk_int("hold_valid", int'(valid_out), 1);
                chk("hold_data", dout, hd);
            end
            if (valid_out && ready_in) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got {%0d,%0d} with no beat outstanding",
                             $signed(dout[DW-1:0]), $signed(dout[W-1:DW]));
                end else begin
                    chk("out_data", dout, exp_q.pop_front());
                end
            end
            if (clear) exp_q.delete();
            held = valid_out && !ready_in;
            hd   = dout;
        end
    end

    initial begin
        int j;
        int b;
        int a0;
        int a1;
        bit c;
        bit v;
        bit rdy;

        repeat (2) @(negedge clk);
        chk_int("rst_valid_o", int'(valid_out), 0);
        chk("rst_data_o", dout, '0);
        chk_int("rst_ready_o", int'(ready_out), 1);
        rst_n = 1'b1;
        @(negedge clk);

        // Multiples of Q reduce to zero, exactly three cycles after acceptance, for one cycle.
        step(1'b1, pk(3329, -3329), 1'b0, 1'b1, 1'b0, pk(0, 0));
        check_latency("t1_latency");
        idle();
        chk_int("t1_single_beat", int'(valid_out), 0);

        // Range extremes and rounding boundaries, mixed modes back to back.
        step(1'b1, pk(32767, -32768), 1'b0, 1'b1, 1'b0, pk(-523, 522));
        step(1'b1, pk(32767, -32768), 1'b1, 1'b1, 1'b0, pk(2806, 522));
        step(1'b1, pk(1665, 1664),    1'b0, 1'b1, 1'b0, pk(-1664, 1664));
        step(1'b1, pk(1665, -1),      1'b1, 1'b1, 1'b0, pk(1665, 3328));
        drain("t2_drain");

        // Back-pressure: eight beats, downstream stalls for cycles 4..7.
        b = 0;
        j = 0;
        while (b < 8 && j < 100) begin
            rdy = !(j >= 4 && j <= 7);
            step(1'b1, pk((b + 1) * 3330, -(b + 1) * 100), 1'b0, rdy, 1'b0,
                 pk(b + 1, -(b + 1) * 100));
            if (fire) b++;
            j++;
        end
        chk_int("bp_all_sent", b, 8);
        drain("bp_drain");

        // Clear with two beats in flight and a third offered in the same cycle.
        step(1'b1, pk(10, 20), 1'b0, 1'b1, 1'b0, pk(10, 20));
        step(1'b1, pk(30, 40), 1'b0, 1'b1, 1'b0, pk(30, 40));
        step(1'b1, pk(50, 60), 1'b0, 1'b1, 1'b1, pk(50, 60));
        for (int i = 0; i < 5; i++) begin
            chk_int("clr_no_valid", int'(valid_out), 0);
            idle();
        end
        step(1'b1, pk(-5, 7), 1'b1, 1'b1, 1'b0, pk(3324, 7));
        check_latency("clr_next_latency");
        drain("clr_drain");

        // Random beats, modes and stalls inside the guaranteed-centred input range.
        for (int i = 0; i < 400; i++) begin
            a0  = int'($urandom_range(0, 58876)) - 29438;
            a1  = int'($urandom_range(0, 58876)) - 29438;
            c   = 1'($urandom_range(0, 1));
            v   = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 3) != 0);
            step(v, pk(a0, a1), c, rdy, 1'b0, pk(mref(a0, c), mref(a1, c)));
        end
        drain("rand_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
